// File: rtl/stack_ctrl.sv
// stack_ctrl
// Sequences PUSH / POP / CALL / RET requests from a control unit onto an
// external 8-bit stack. The controller tracks stack occupancy, rejects
// requests that would overflow or underflow the stack, and returns one
// completion strobe per accepted request.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_op               00 PUSH, 01 POP, 10 CALL, 11 RET
//   req_data             value to push (PUSH) or branch target (CALL)
//   pc                   program counter sampled at acceptance
//   stk_op/stk_wdata     stack command (00 NOP, 01 push, 10 pop) and push data
//   stk_rdata            top-of-stack value, valid the cycle after a pop
//   rsp_valid            one-cycle completion strobe
//   rsp_data             pushed value, CALL target, popped value or return PC
//   rsp_pc_load          completed CALL/RET: load rsp_data into the PC
//   rsp_err              request was rejected
//   err_ovf/err_unf      sticky overflow / underflow flags
//   depth                number of occupied stack entries
module stack_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    input  logic [7:0] pc,
    output logic [1:0] stk_op,
    output logic [7:0] stk_wdata,
    input  logic [7:0] stk_rdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_pc_load,
    output logic       rsp_err,
    output logic       err_ovf,
    output logic       err_unf,
    output logic [4:0] depth
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [4:0] FULL = 5'(DEPTH);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_q;
    logic [7:0] data_q;
    logic [7:0] pc_q;
    logic       rej_q;
    logic       accept;
    logic       reject_now;

    // Bit 0 of the opcode separates pop-type (POP, RET) from push-type
    // (PUSH, CALL); bit 1 marks the PC-changing variants (CALL, RET).
    always_comb begin
        accept     = req_valid && req_ready;
        reject_now = req_op[0] ? (depth == 5'd0) : (depth == FULL);
    end

    // Next-state and output decode. The stack command is gated by rst_n so a
    // request caught in ISSUE when reset arrives never reaches the stack.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        stk_op      = 2'b00;
        stk_wdata   = 8'h00;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_pc_load = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (accept) begin
                    state_nxt = reject_now ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (rst_n) begin
                    if (op_q[0]) begin
                        stk_op = 2'b10;
                    end else begin
                        stk_op    = 2'b01;
                        stk_wdata = op_q[1] ? (pc_q + 8'd1) : data_q;
                    end
                end
                state_nxt = op_q[0] ? WAIT : RESP;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_err     = rej_q;
                rsp_pc_load = !rej_q && op_q[1];
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, occupancy tracking, sticky error flags and the
    // response data register. Depth moves in the ISSUE cycle, i.e. on the
    // same edge the stack itself acts on the command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            data_q   <= 8'h00;
            pc_q     <= 8'h00;
            rej_q    <= 1'b0;
            depth    <= 5'd0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
            rsp_data <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        data_q <= req_data;
                        pc_q   <= pc;
                        rej_q  <= reject_now;
                        if (reject_now) begin
                            if (req_op[0]) begin
                                err_unf <= 1'b1;
                            end else begin
                                err_ovf <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (op_q[0]) begin
                        depth <= depth - 5'd1;
                    end else begin
                        depth    <= depth + 5'd1;
                        rsp_data <= data_q;
                    end
                end
                WAIT: begin
                    rsp_data <= stk_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
